// File: rtl/census_3x3.sv
// census_3x3: streaming 3x3 census transform.
// Pixels arrive in raster order with their X/Y coordinates. Two line buffers
// supply the two rows above the incoming pixel. Every interior pixel yields an
// 8-bit descriptor: each bit is set when that neighbour is darker than the centre.
module census_3x3 #(
    parameter  int frameW = 640,
    parameter  int frameH = 480,
    parameter  int PIX_W  = 8,
    localparam int XW     = $clog2(frameW) + 1,
    localparam int YW     = $clog2(frameH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] pix_in,
    input  logic [XW-1:0]    X_in,
    input  logic [YW-1:0]    Y_in,
    output logic             out_valid,
    output logic [7:0]       census,
    output logic [XW-1:0]    X_out,
    output logic [YW-1:0]    Y_out
);

    localparam int AW = $clog2(frameW);

    logic                   w_accept;
    logic                   w_emit;
    logic [7:0]             w_census;
    logic [2:0][PIX_W-1:0]  w_colNew;

    logic                   r_s1Valid;
    logic [PIX_W-1:0]       r_s1Pix;
    logic [XW-1:0]          r_s1X;
    logic [YW-1:0]          r_s1Y;

    logic                   r_s2Valid;
    logic [PIX_W-1:0]       r_s2Pix;
    logic [XW-1:0]          r_s2X;
    logic [YW-1:0]          r_s2Y;

    logic [PIX_W-1:0]       r_lb0 [frameW];
    logic [PIX_W-1:0]       r_lb1 [frameW];
    logic [PIX_W-1:0]       r_rd0;
    logic [PIX_W-1:0]       r_rd1;

    // Window columns: index 0 = row Y-2, 1 = row Y-1, 2 = row Y.
    // r_win1 holds column X-2 and r_win2 holds column X-1 while pixel X is in
    // stage 2. The newest column is the live w_colNew.
    logic [2:0][PIX_W-1:0]  r_win1;
    logic [2:0][PIX_W-1:0]  r_win2;

    // Qualify pixels, assemble the incoming column and form the descriptor
    always_comb begin
        w_accept = en && (X_in < XW'(frameW)) && (Y_in < YW'(frameH));
        w_colNew = {r_s2Pix, r_rd0, r_rd1};
        w_emit   = r_s2Valid && (r_s2X >= XW'(2)) && (r_s2Y >= YW'(2));

        w_census[7] = r_win1[0]   < r_win2[1];
        w_census[6] = r_win2[0]   < r_win2[1];
        w_census[5] = w_colNew[0] < r_win2[1];
        w_census[4] = r_win1[1]   < r_win2[1];
        w_census[3] = w_colNew[1] < r_win2[1];
        w_census[2] = r_win1[2]   < r_win2[1];
        w_census[1] = r_win2[2]   < r_win2[1];
        w_census[0] = w_colNew[2] < r_win2[1];
    end

    // Input capture and delay stage that carries each pixel alongside its line-buffer read
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1Valid <= 1'b0;
            r_s1Pix   <= '0;
            r_s1X     <= '0;
            r_s1Y     <= '0;
            r_s2Valid <= 1'b0;
            r_s2Pix   <= '0;
            r_s2X     <= '0;
            r_s2Y     <= '0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Pix <= pix_in;
                r_s1X   <= X_in;
                r_s1Y   <= Y_in;
            end
            r_s2Valid <= r_s1Valid;
            r_s2Pix   <= r_s1Pix;
            r_s2X     <= r_s1X;
            r_s2Y     <= r_s1Y;
        end
    end

    // Line buffers: synchronous read at the pixel's column; write back one cycle later, pushing lb0 down into lb1
    always_ff @(posedge clk) begin
        r_rd0 <= r_lb0[r_s1X[AW-1:0]];
        r_rd1 <= r_lb1[r_s1X[AW-1:0]];
        if (r_s2Valid) begin
            r_lb0[r_s2X[AW-1:0]] <= r_s2Pix;
            r_lb1[r_s2X[AW-1:0]] <= r_rd0;
        end
    end

    // Window shift on valid pixels only, registered descriptor output held between pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_win1    <= '0;
            r_win2    <= '0;
            out_valid <= 1'b0;
            census    <= '0;
            X_out     <= '0;
            Y_out     <= '0;
        end else begin
            out_valid <= w_emit;
            if (r_s2Valid) begin
                r_win1 <= r_win2;
                r_win2 <= w_colNew;
            end
            if (w_emit) begin
                census <= w_census;
                X_out  <= r_s2X - XW'(1);
                Y_out  <= r_s2Y - YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_census_3x3.sv
// tb_census_3x3: scoreboard bench for the census stage on an 8x6 frame.
// Stimulus pushes each expected descriptor with the cycle it must appear on.
// An independent monitor pops and compares whenever the DUT pulses or an entry falls due.
module tb_census_3x3;

    localparam int FW = 8;
    localparam int FH = 6;
    localparam int XW = $clog2(FW) + 1;
    localparam int YW = $clog2(FH) + 1;

    typedef struct {
        logic [7:0] census;
        int         x;
        int         y;
        int         due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [7:0]    pix_in = '0;
    logic [XW-1:0] X_in = '0;
    logic [YW-1:0] Y_in = '0;
    logic          out_valid;
    logic [7:0]    census;
    logic [XW-1:0] X_out;
    logic [YW-1:0] Y_out;

    exp_t       sbQueue[$];
    exp_t       monE;
    bit         expPulse;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         pulseCount = 0;
    int         mode = 0;
    logic [7:0] img [FH][FW];

    census_3x3 #(.frameW(FW), .frameH(FH), .PIX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pix_in    (pix_in),
        .X_in      (X_in),
        .Y_in      (Y_in),
        .out_valid (out_valid),
        .census    (census),
        .X_out     (X_out),
        .Y_out     (Y_out)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected results
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Golden census from the full 2D image
    function automatic logic [7:0] modelCensus(input int cx, input int cy);
        logic [7:0] c;
        logic [7:0] r;
        int         k;
        c = img[cy][cx];
        r = '0;
        k = 7;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0)) begin
                    r[k] = (img[cy+dy][cx+dx] < c);
                    k--;
                end
            end
        end
        return r;
    endfunction

    // Hand-derived descriptors for the directed images; model only for random data
    function automatic logic [7:0] expFor(input int cx, input int cy);
        case (mode)
            0:       return 8'h00;
            1:       return 8'h94;
            2:       return 8'hE0;
            3:       return (cx == 3 && cy == 3) ? 8'hFF : 8'h00;
            default: return modelCensus(cx, cy);
        endcase
    endfunction

    task automatic fillImage(input int m);
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                case (m)
                    0:       img[y][x] = 8'h55;
                    1:       img[y][x] = 8'(x * 10);
                    2:       img[y][x] = 8'(y * 10);
                    3:       img[y][x] = (x == 3 && y == 3) ? 8'hFF : 8'h10;
                    default: img[y][x] = 8'($urandom);
                endcase
            end
        end
    endtask

    task automatic applyStimulus(input bit e, input int x, input int y);
        @(negedge clk);
        en   = e;
        X_in = XW'(x);
        Y_in = YW'(y);
        if (x < FW && y < FH) pix_in = img[y][x];
        else                  pix_in = 8'($urandom);
        if (e && x < FW && y < FH && x >= 2 && y >= 2)
            sbQueue.push_back('{expFor(x - 1, y - 1), x - 1, y - 1, cyc + 3});
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 0);
        checkOutput("drainEmpty", sbQueue.size(), 0);
    endtask

    task automatic runFrame(input int m, input bit gaps);
        mode = m;
        fillImage(m);
        pulseCount = 0;
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                if (gaps) begin
                    for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++)
                        applyStimulus(1'b0, x, y);
                end
                applyStimulus(1'b1, x, y);
            end
        end
        drain();
        checkOutput("pulseCount", pulseCount, (FW - 2) * (FH - 2));
    endtask

    // Monitor: every cycle, compare the pulse against the scoreboard head
    always @(posedge clk) begin
        #1;
        while (sbQueue.size() > 0 && sbQueue[0].due < cyc) begin
            monE = sbQueue.pop_front();
            checkOutput("staleEntry", monE.due, cyc);
        end
        expPulse = (sbQueue.size() > 0) && (sbQueue[0].due == cyc);
        checkOutput("pulse", int'(out_valid), int'(expPulse));
        if (out_valid) pulseCount++;
        if (expPulse) begin
            monE = sbQueue.pop_front();
            if (out_valid) begin
                checkOutput("census", int'(census), int'(monE.census));
                checkOutput("X_out", int'(X_out), monE.x);
                checkOutput("Y_out", int'(Y_out), monE.y);
            end
        end
    end

    // Main sequence
    initial begin
        mode = 0;
        fillImage(0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetValid", int'(out_valid), 0);
        checkOutput("resetCensus", int'(census), 0);
        checkOutput("resetX", int'(X_out), 0);
        checkOutput("resetY", int'(Y_out), 0);
        rst = 1'b1;

        runFrame(0, 1'b0);
        runFrame(1, 1'b0);
        runFrame(2, 1'b0);
        runFrame(3, 1'b0);
        runFrame(1, 1'b1);
        runFrame(2, 1'b1);

        // Reset in the middle of a frame at pixel (4,3)
        mode = 1;
        fillImage(1);
        for (int i = 0; i < 3 * FW + 4; i++) applyStimulus(1'b1, i % FW, i / FW);
        @(negedge clk);
        rst    = 1'b0;
        en     = 1'b1;
        X_in   = XW'(4);
        Y_in   = YW'(3);
        pix_in = img[3][4];
        sbQueue.delete();
        @(posedge clk);
        #2;
        checkOutput("midResetValid", int'(out_valid), 0);
        checkOutput("midResetCensus", int'(census), 0);
        checkOutput("midResetX", int'(X_out), 0);
        checkOutput("midResetY", int'(Y_out), 0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        runFrame(1, 1'b0);

        // Out-of-range pixels past the frame end, then a fresh random frame
        pulseCount = 0;
        for (int i = 0; i < FW; i++) applyStimulus(1'b1, i, FH);
        applyStimulus(1'b1, FW, 2);
        applyStimulus(1'b1, FW, 3);
        drain();
        checkOutput("oorPulses", pulseCount, 0);
        runFrame(4, 1'b0);
        runFrame(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
